pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program sequencer for the picoMIPS accumulator datapath. It owns the program counter that addresses the combinational program memory (`Psize`-bit address, `Isize`-bit instruction). It decodes each fetched instruction into registered one-cycle datapath strobes, and it implements the `HEI` wait-for-switch handshake with a synchronised, debounced SW8. It sits between the program memory and the accumulator/register-file datapath.

## Interface
- `Psize`, 5: program address width.
- `Isize`, 15: instruction width; opcode is `I[Isize-1:8]`, immediate is `I[7:0]`.
- `Plast`, 30: last valid program address; the PC wraps to 0 after it.
- `DB_CYCLES`, 4: consecutive stable cycles required before the debounced SW8 changes.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `I` in `Isize`: instruction from program memory at `address`, valid in the same cycle.
- `sw8` in 1: raw SW8 level, asynchronous.
- `address` out `Psize`: program counter, registered.
- `acc_we` out 1: accumulator write strobe.
- `acc_sel` out 2: accumulator operation. 00 = multiply by imm, 01 = add SW[7:0], 10 = add imm, 11 = add reg.
- `reg_we` out 1: register-file write strobe (reg ← accum).
- `reg_addr` out 1: register select, taken from `I[0]`.
- `imm` out 8: immediate for the strobed operation.
- `waiting` out 1: high while stalled in `HEI`.

## Operation
- Opcode encodings for `HEI`, `MULI`, `ADDS`, `ADDI`, `STR` and `ADDR` come from the shared opcode definitions. Any other opcode is a NOP.
- SW8 path:
  - two-flop synchroniser `s1` → `s2`.
  - debounced level `sw_db` with counter `db_cnt`.
  - `db_cnt` clears whenever `s2 == sw_db`; otherwise it increments.
  - When `db_cnt` reaches `DB_CYCLES-1` while mismatched, `sw_db <= s2` and `db_cnt <= 0`.
- States: `RUN`, `WAIT`.
- `RUN`, non-`HEI` instruction:
  - register the decode into the outputs (see mapping below).
  - `address <= (address == Plast) ? 0 : address + 1`.
- Decode mapping:
  - `MULI`: `acc_we=1`, `acc_sel=00`.
  - `ADDS`: `acc_we=1`, `acc_sel=01`.
  - `ADDI`: `acc_we=1`, `acc_sel=10`.
  - `ADDR`: `acc_we=1`, `acc_sel=11`, `reg_addr=I[0]`.
  - `STR`: `reg_we=1`, `reg_addr=I[0]`.
  - NOP: no strobe.
  - `imm <= I[7:0]` for every instruction.
- `RUN`, `HEI`:
  - if `sw_db == I[0]`: no strobe, PC advances, stay in `RUN`.
  - else: go to `WAIT`, PC held, `waiting <= 1`.
- `WAIT`:
  - PC held, strobes 0.
  - when `sw_db == I[0]`: go to `RUN`, `waiting <= 0`, PC advances in the same edge.
- Strobes are single-cycle. Any cycle without a new decode drives `acc_we = reg_we = 0`.
- `address` values above `Plast` (reachable only through a parameter misuse) also wrap to 0 on advance.

## Timing
- Reset values: `address=0`, state `RUN`, `acc_we=0`, `reg_we=0`, `acc_sel=00`, `reg_addr=0`, `imm=0`, `waiting=0`, `s1=s2=sw_db=0`, `db_cnt=0`.
- Reset asserted mid-program or mid-`WAIT` reaches exactly these values at the next edge. The pending strobe is dropped.
- Decode latency is 1 cycle. The strobe for the instruction at address n is high in the cycle after `address == n`, i.e. concurrent with `address == n+1`.
  - A `STR rk` followed by `ADDR rk` therefore writes before it reads.
- Throughput is one instruction per cycle outside `HEI` stalls.
- An `HEI` that is already satisfied costs 1 cycle. An unsatisfied `HEI` exits at the first edge where `sw_db` matches.
- SW8 latency: a level held stable from edge k is visible in `sw_db` after edge `k+1+DB_CYCLES`.
- A glitch shorter than `DB_CYCLES` cycles at `s2` never changes `sw_db`.
- Wrap-around: an instruction at `Plast` is decoded normally; the next `address` is 0.
- Simultaneous events: `reset` has priority over the wrap, `HEI` exit and decode.

## Structure
- Shared package `picomips_pkg` holds:
  - the opcode constants;
  - the `acc_sel` enum (`ACC_MUL_IMM`, `ACC_ADD_SW`, `ACC_ADD_IMM`, `ACC_ADD_REG`);
  - the state enum (`RUN`, `WAIT`).
- One sub-module, `sw_debounce`, implements the synchroniser and debounce (`clk`, `reset`, `sw8` → `sw_db`). The FSM, PC and decode registers live in `pc_sequencer`.

## Test plan
- Reset: hold `reset` for 3 cycles mid-run at `address=7` → next edge `address=0`, all strobes 0, `waiting=0`.
- Straight-line decode: `MULI 0x60`, `ADDI 0x14`, `STR 1` → strobes appear one cycle later:
  - `acc_we=1` with `acc_sel=00`, `imm=0x60`;
  - then `acc_sel=10`, `imm=0x14`;
  - then `reg_we=1` with `reg_addr=1`.
- `HEI 0` with `sw_db=0` at address 0:
  - `waiting=1`, `address` frozen at 0;
  - raise `sw8`: `address` becomes 1 at edge `k+2+DB_CYCLES`, with `waiting` dropping on the same edge.
- Debounce: pulse `sw8` high for 3 cycles (`DB_CYCLES=4`) during `HEI 0` → `sw_db` stays 0 and the PC stays frozen.
- Wrap: run to `address=30` (`Plast`) holding `ADDR 1` → `acc_sel=11`, `reg_addr=1` strobe, `address=0` next.
- Illegal opcode `7'h7F` → no strobe, PC advances by 1.

Source files
------------

// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: opcode encodings, accumulator operation select
// and sequencer state encoding.
package picomips_pkg;

   localparam int OP_W = 7;

   localparam logic [OP_W-1:0] OP_HEI  = 7'h01;
   localparam logic [OP_W-1:0] OP_MULI = 7'h02;
   localparam logic [OP_W-1:0] OP_ADDS = 7'h03;
   localparam logic [OP_W-1:0] OP_ADDI = 7'h04;
   localparam logic [OP_W-1:0] OP_STR  = 7'h05;
   localparam logic [OP_W-1:0] OP_ADDR = 7'h06;

   typedef enum logic [1:0] {
      ACC_MUL_IMM = 2'b00,
      ACC_ADD_SW  = 2'b01,
      ACC_ADD_IMM = 2'b10,
      ACC_ADD_REG = 2'b11
   } acc_sel_t;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pc_sequencer_sw_debounce.sv
// SW8 conditioning: two-flop synchroniser followed by a stable-count debouncer.
module sw_debounce
   import picomips_pkg::*;
#(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic sw8,
   output logic sw_db
);

   localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             s1_q, s2_q, sw_db_q, sw_db_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

   always_comb begin
      sw_db_d  = sw_db_q;
      db_cnt_d = '0;
      // Any return to agreement discards the partial count, so short glitches vanish.
      if (s2_q != sw_db_q) begin
         if (db_cnt_q == CNT_LAST) begin
            sw_db_d = s2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         sw_db_q  <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         s1_q     <= sw8;
         s2_q     <= s1_q;
         sw_db_q  <= sw_db_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign sw_db = sw_db_q;

endmodule

// File: rtl/pc_sequencer.sv
// picoMIPS program sequencer: program counter, registered one-cycle decode
// strobes and the HEI wait-for-switch stall.
module pc_sequencer
   import picomips_pkg::*;
#(
   parameter int Psize     = 5,
   parameter int Isize     = 15,
   parameter int Plast     = 30,
   parameter int DB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [Isize-1:0] I,
   input  logic             sw8,
   output logic [Psize-1:0] address,
   output logic             acc_we,
   output logic [1:0]       acc_sel,
   output logic             reg_we,
   output logic             reg_addr,
   output logic [7:0]       imm,
   output logic             waiting
);

   logic             sw_db;
   logic [OP_W-1:0]  op;
   logic [Psize-1:0] next_pc;

   state_t           state_q, state_d;
   logic [Psize-1:0] address_q, address_d;
   logic             acc_we_q, acc_we_d, reg_we_q, reg_we_d;
   acc_sel_t         acc_sel_q, acc_sel_d;
   logic             reg_addr_q, reg_addr_d, waiting_q, waiting_d;
   logic [7:0]       imm_q, imm_d;

   sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_sw_debounce (
      .clk   (clk),
      .reset (reset),
      .sw8   (sw8),
      .sw_db (sw_db)
   );

   assign op = I[Isize-1:8];
   // Out-of-range addresses also wrap, so a bad Plast cannot run the PC off the end.
   assign next_pc = (address_q >= Psize'(Plast)) ? '0 : address_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      address_d  = address_q;
      acc_we_d   = 1'b0;
      reg_we_d   = 1'b0;
      acc_sel_d  = acc_sel_q;
      reg_addr_d = reg_addr_q;
      imm_d      = imm_q;
      waiting_d  = waiting_q;
      case (state_q)
         RUN: begin
            if (op == OP_HEI) begin
               if (sw_db == I[0]) begin
                  address_d = next_pc;
               end else begin
                  state_d   = WAIT;
                  waiting_d = 1'b1;
               end
            end else begin
               address_d = next_pc;
               imm_d     = I[7:0];
               case (op)
                  OP_MULI: begin acc_we_d = 1'b1; acc_sel_d = ACC_MUL_IMM; end
                  OP_ADDS: begin acc_we_d = 1'b1; acc_sel_d = ACC_ADD_SW;  end
                  OP_ADDI: begin acc_we_d = 1'b1; acc_sel_d = ACC_ADD_IMM; end
                  OP_ADDR: begin
                     acc_we_d   = 1'b1;
                     acc_sel_d  = ACC_ADD_REG;
                     reg_addr_d = I[0];
                  end
                  OP_STR: begin reg_we_d = 1'b1; reg_addr_d = I[0]; end
                  default: ;
               endcase
            end
         end
         WAIT: begin
            if (sw_db == I[0]) begin
               state_d   = RUN;
               waiting_d = 1'b0;
               address_d = next_pc;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         address_q  <= '0;
         acc_we_q   <= 1'b0;
         reg_we_q   <= 1'b0;
         acc_sel_q  <= ACC_MUL_IMM;
         reg_addr_q <= 1'b0;
         imm_q      <= '0;
         waiting_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         address_q  <= address_d;
         acc_we_q   <= acc_we_d;
         reg_we_q   <= reg_we_d;
         acc_sel_q  <= acc_sel_d;
         reg_addr_q <= reg_addr_d;
         imm_q      <= imm_d;
         waiting_q  <= waiting_d;
      end
   end

   assign address  = address_q;
   assign acc_we   = acc_we_q;
   assign acc_sel  = acc_sel_q;
   assign reg_we   = reg_we_q;
   assign reg_addr = reg_addr_q;
   assign imm      = imm_q;
   assign waiting  = waiting_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: program memory modelled as a bench array.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [14:0] I;
   logic        sw8;
   logic [4:0]  address;
   logic        acc_we;
   logic [1:0]  acc_sel;
   logic        reg_we;
   logic        reg_addr;
   logic [7:0]  imm;
   logic        waiting;

   logic [14:0] prog [0:31];
   int n_cmp = 0;
   int n_err = 0;

   localparam logic [6:0] HEI = 7'h01, MULI = 7'h02, ADDS = 7'h03,
                          ADDI = 7'h04, STR = 7'h05, ADDR = 7'h06, NOP = 7'h00;

   pc_sequencer #(.Psize(5), .Isize(15), .Plast(30), .DB_CYCLES(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .I        (I),
      .sw8      (sw8),
      .address  (address),
      .acc_we   (acc_we),
      .acc_sel  (acc_sel),
      .reg_we   (reg_we),
      .reg_addr (reg_addr),
      .imm      (imm),
      .waiting  (waiting)
   );

   assign I = prog[address];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [14:0] ins(input logic [6:0] op, input logic [7:0] im);
      return {op, im};
   endfunction

   task automatic fill(input logic [14:0] v);
      for (int i = 0; i < 32; i++) prog[i] = v;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      sw8   = 1'b0;
      fill(ins(NOP, 8'h00));

      // reset values
      tick(2);
      chk("rst_addr", address, 0);
      chk("rst_accwe", acc_we, 0);
      chk("rst_regwe", reg_we, 0);
      chk("rst_sel", acc_sel, 0);
      chk("rst_raddr", reg_addr, 0);
      chk("rst_imm", imm, 0);
      chk("rst_wait", waiting, 0);
      reset = 1'b0;

      // mid-run reset at address 7 drops the pending MULI strobe
      prog[7] = ins(MULI, 8'h33);
      tick(7);
      chk("run_addr7", address, 7);
      reset = 1'b1;
      tick(1);
      chk("mid_rst_addr", address, 0);
      chk("mid_rst_accwe", acc_we, 0);
      chk("mid_rst_regwe", reg_we, 0);
      chk("mid_rst_wait", waiting, 0);
      tick(2);
      reset = 1'b0;

      // straight-line decode
      fill(ins(NOP, 8'h00));
      prog[0] = ins(MULI, 8'h60);
      prog[1] = ins(ADDI, 8'h14);
      prog[2] = ins(STR,  8'h01);
      prog[3] = ins(ADDS, 8'h00);
      do_reset();
      chk("sl_addr0", address, 0);
      tick(1);
      chk("muli_addr", address, 1);
      chk("muli_we", acc_we, 1);
      chk("muli_sel", acc_sel, 0);
      chk("muli_imm", imm, 8'h60);
      tick(1);
      chk("addi_we", acc_we, 1);
      chk("addi_sel", acc_sel, 2);
      chk("addi_imm", imm, 8'h14);
      tick(1);
      chk("str_accwe", acc_we, 0);
      chk("str_regwe", reg_we, 1);
      chk("str_raddr", reg_addr, 1);
      tick(1);
      chk("adds_we", acc_we, 1);
      chk("adds_sel", acc_sel, 1);
      chk("adds_regwe", reg_we, 0);
      tick(1);
      chk("nop_accwe", acc_we, 0);
      chk("nop_addr", address, 5);

      // satisfied HEI costs one cycle
      fill(ins(NOP, 8'h00));
      prog[0] = ins(HEI, 8'h00);
      do_reset();
      tick(1);
      chk("hei_sat_addr", address, 1);
      chk("hei_sat_wait", waiting, 0);
      chk("hei_sat_we", acc_we, 0);

      // unsatisfied HEI, then sw8 raised and held
      prog[0] = ins(HEI, 8'h01);
      do_reset();
      tick(1);
      chk("hei_wait", waiting, 1);
      chk("hei_addr", address, 0);
      tick(3);
      chk("hei_frozen", address, 0);
      sw8 = 1'b1;             // next edge is k
      tick(6);                // edges k..k+5
      chk("hei_pre_addr", address, 0);
      chk("hei_pre_wait", waiting, 1);
      tick(1);                // edge k+6
      chk("hei_exit_addr", address, 1);
      chk("hei_exit_wait", waiting, 0);

      // 3-cycle glitch never releases the stall
      sw8 = 1'b0;
      do_reset();
      tick(2);
      chk("glitch_wait0", waiting, 1);
      sw8 = 1'b1;
      tick(3);
      sw8 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk($sformatf("glitch_addr%0d", i), address, 0);
      end
      chk("glitch_wait", waiting, 1);
      // reset while stalled
      reset = 1'b1;
      tick(1);
      chk("wait_rst_wait", waiting, 0);
      chk("wait_rst_addr", address, 0);
      reset = 1'b0;

      // wrap at Plast with ADDR r1
      fill(ins(ADDR, 8'h01));
      do_reset();
      tick(30);
      chk("wrap_pre", address, 30);
      tick(1);
      chk("wrap_addr", address, 0);
      chk("wrap_we", acc_we, 1);
      chk("wrap_sel", acc_sel, 3);
      chk("wrap_raddr", reg_addr, 1);

      // illegal opcode is a NOP
      fill(ins(NOP, 8'h00));
      prog[0] = ins(7'h7F, 8'h55);
      do_reset();
      tick(1);
      chk("ill_addr", address, 1);
      chk("ill_accwe", acc_we, 0);
      chk("ill_regwe", reg_we, 0);
      chk("ill_imm", imm, 8'h55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
